instruction_fetcher: RTL and testbench
======================================

Name: instruction_fetcher

Overview:
- Per-core fetch stage that sits directly upstream of the instruction decoder.
- While the scheduler is in FETCH, it obtains the 16-bit instruction at the current PC. The word comes from a small direct-mapped instruction cache on a hit, or from program memory via a valid/ready handshake on a miss.
- It presents the instruction and a FETCHED status to the scheduler. The decoder consumes the instruction in the following DECODE state.

Parameters:
- PROGRAM_ADDR_BITS, 8, program memory address / PC width.
- PROGRAM_DATA_BITS, 16, instruction width.
- CACHE_LINES, 4, number of one-word cache lines; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset: asserted when 0.
- core_state  in  3  scheduler state: 000 IDLE, 001 FETCH, 010 DECODE, 011 REQUEST, 100 WAIT, 101 EXECUTE, 110 UPDATE, 111 DONE.
- current_pc  in  PROGRAM_ADDR_BITS  PC to fetch; stable while core_state = FETCH.
- flush  in  1  invalidate all cache lines (program reload).
- mem_read_valid  out  1  program memory read request.
- mem_read_address  out  PROGRAM_ADDR_BITS  request address.
- mem_read_ready  in  1  memory response strobe; data valid this cycle.
- mem_read_data  in  PROGRAM_DATA_BITS  response data.
- fetcher_state  out  3  000 IDLE, 001 FETCHING, 010 FETCHED.
- instruction  out  PROGRAM_DATA_BITS  fetched instruction, held until the next fetch completes.
- cache_hit  out  1  one-cycle pulse when a fetch is served from the cache.

Behaviour:
- Reset (reset = 0, asynchronous):
  - fetcher_state = IDLE; mem_read_valid = 0; mem_read_address = 0; instruction = 0; cache_hit = 0.
  - All cache valid bits cleared.
  - Takes effect immediately, including mid-transaction. Any outstanding memory request is abandoned, and a later mem_read_ready is ignored unless state is FETCHING.
- Cache organisation:
  - index = current_pc[log2(CACHE_LINES)-1:0]; tag = remaining upper PC bits.
  - Each line holds valid, tag and data. Tag/data storage needs no reset; only the valid bits are reset.
- IDLE, when core_state = 001 (FETCH):
  - Hit (line valid, tag match): instruction <= line data, cache_hit <= 1 for one cycle, go to FETCHED. Latency is 1 cycle.
  - Miss: mem_read_valid <= 1, mem_read_address <= current_pc, go to FETCHING.
  - In any other core_state, IDLE holds and outputs hold.
- FETCHING:
  - mem_read_valid and mem_read_address stay stable until mem_read_ready = 1.
  - On ready: instruction <= mem_read_data; line[index] <= {valid 1, tag, data}; mem_read_valid <= 0; go to FETCHED.
  - Miss latency = memory latency + 1 cycle. mem_read_ready may arrive in the first FETCHING cycle.
  - The request is never aborted by core_state changes; only reset aborts it.
- FETCHED:
  - instruction holds.
  - When core_state = 010 (DECODE), go to IDLE; otherwise stay in FETCHED.
- cache_hit is 0 in every cycle except the hit transition cycle.
- flush = 1 clears all valid bits on the next edge; fetch in progress is unaffected.
  - Flush coinciding with a fill: the fill's instruction is still delivered to the instruction output, but the line is left invalid (flush wins).
  - Flush coinciding with a hit lookup: the hit is still served that cycle.
- mem_read_ready while not FETCHING is ignored.
- PC wrap-around needs no special handling; the address is used as-is.

Test Plan:
- Cold miss:
  - Stimulus: after reset release, core_state = 001, pc = 0x05; memory returns 0x3123 after 3 cycles.
  - Response: mem_read_valid high with address 0x05 for exactly 3 cycles, then FETCHED with instruction = 0x3123 and cache_hit = 0.
- Hit:
  - Stimulus: go through DECODE back to IDLE, then FETCH pc = 0x05 again.
  - Response: FETCHED one cycle later, instruction = 0x3123, cache_hit pulse of one cycle, mem_read_valid never asserted.
- Conflict:
  - Stimulus: fetch pc = 0x09 (same index 1, different tag) returning 0x9A07, then fetch pc = 0x05.
  - Response: both fetches miss, and the second re-requests address 0x05.
- Flush:
  - Stimulus: flush during a fill whose data is 0xF000.
  - Response: instruction = 0xF000; refetching the same PC misses.
- Reset mid-fetch:
  - Stimulus: drive reset low while FETCHING.
  - Response: mem_read_valid = 0 and fetcher_state = 000 immediately (before the next clock edge); a following mem_read_ready pulse has no effect; the previous hit PC now misses.
- Hold:
  - Stimulus: hold core_state = 001 for 10 cycles after FETCHED.
  - Response: state stays FETCHED and instruction stays stable; no new request is issued.

Source files
------------

// File: rtl/instruction_fetcher.sv
// Fetch stage: serves the instruction at current_pc from a direct-mapped
// one-word-per-line cache, or from program memory through a valid/ready handshake.
module instruction_fetcher #(
  parameter int PROGRAM_ADDR_BITS = 8,
  parameter int PROGRAM_DATA_BITS = 16,
  parameter int CACHE_LINES       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   core_state,
  input  logic [PROGRAM_ADDR_BITS-1:0] current_pc,
  input  logic                         flush,
  output logic                         mem_read_valid,
  output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
  input  logic                         mem_read_ready,
  input  logic [PROGRAM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                   fetcher_state,
  output logic [PROGRAM_DATA_BITS-1:0] instruction,
  output logic                         cache_hit
);

  localparam int INDEX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS   = PROGRAM_ADDR_BITS - INDEX_BITS;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_FETCHING = 3'b001,
    ST_FETCHED  = 3'b010
  } fetch_state_t;

  fetch_state_t state, state_next;

  logic [CACHE_LINES-1:0]       line_valid;
  logic [TAG_BITS-1:0]          line_tag  [CACHE_LINES];
  logic [PROGRAM_DATA_BITS-1:0] line_data [CACHE_LINES];

  logic [INDEX_BITS-1:0] lookup_index, fill_index;
  logic [TAG_BITS-1:0]   lookup_tag, fill_tag;
  logic                  lookup_hit;
  logic                  start_hit, start_miss, fill;

  assign lookup_index = current_pc[INDEX_BITS-1:0];
  assign lookup_tag   = current_pc[PROGRAM_ADDR_BITS-1:INDEX_BITS];
  assign lookup_hit   = line_valid[lookup_index] && (line_tag[lookup_index] == lookup_tag);

  // The fill uses the latched request address, since current_pc is only
  // guaranteed stable while the scheduler sits in FETCH.
  assign fill_index = mem_read_address[INDEX_BITS-1:0];
  assign fill_tag   = mem_read_address[PROGRAM_ADDR_BITS-1:INDEX_BITS];

  assign fetcher_state = state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (core_state == CORE_FETCH)
                     state_next = lookup_hit ? ST_FETCHED : ST_FETCHING;
      ST_FETCHING: if (mem_read_ready) state_next = ST_FETCHED;
      ST_FETCHED:  if (core_state == CORE_DECODE) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    start_hit  = 1'b0;
    start_miss = 1'b0;
    fill       = 1'b0;
    if (state == ST_IDLE && core_state == CORE_FETCH) begin
      start_hit  = lookup_hit;
      start_miss = !lookup_hit;
    end
    if (state == ST_FETCHING && mem_read_ready) fill = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      cache_hit        <= 1'b0;
    end else begin
      cache_hit <= start_hit;
      if (start_miss) begin
        mem_read_valid   <= 1'b1;
        mem_read_address <= current_pc;
      end else if (fill) begin
        mem_read_valid <= 1'b0;
      end
      if (start_hit)  instruction <= line_data[lookup_index];
      else if (fill)  instruction <= mem_read_data;
    end
  end

  // Flush wins over a coinciding fill: the line stays invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     line_valid <= '0;
    else if (flush) line_valid <= '0;
    else if (fill)  line_valid[fill_index] <= 1'b1;
  end

  // NOTE: tag/data storage has no reset; the valid bits alone make it safe,
  // and leaving it unreset lets it map onto plain RAM/flops without reset muxes.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag[fill_index]  <= fill_tag;
      line_data[fill_index] <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: miss/hit/conflict/flush/reset/hold.
module tb_instruction_fetcher;

  localparam logic [2:0] CS_IDLE   = 3'b000;
  localparam logic [2:0] CS_FETCH  = 3'b001;
  localparam logic [2:0] CS_DECODE = 3'b010;
  localparam logic [2:0] FS_IDLE     = 3'b000;
  localparam logic [2:0] FS_FETCHING = 3'b001;
  localparam logic [2:0] FS_FETCHED  = 3'b010;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic        cache_hit;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_fetcher #(
    .PROGRAM_ADDR_BITS(8),
    .PROGRAM_DATA_BITS(16),
    .CACHE_LINES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_state(core_state),
    .current_pc(current_pc),
    .flush(flush),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state),
    .instruction(instruction),
    .cache_hit(cache_hit)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Miss fetch: memory answers in the lat-th FETCHING cycle (lat >= 1).
  task automatic fetch_miss(input string tag, input logic [7:0] pc, input logic [15:0] data,
                            input int lat, input logic flush_on_fill);
    core_state = CS_FETCH;
    current_pc = pc;
    tick();
    for (int i = 0; i < lat; i++) begin
      check({tag, " state"}, 32'(fetcher_state), 32'(FS_FETCHING));
      check({tag, " valid"}, 32'(mem_read_valid), 32'd1);
      check({tag, " addr"},  32'(mem_read_address), 32'(pc));
      if (i == lat - 1) begin
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        flush          = flush_on_fill;
      end
      tick();
    end
    mem_read_ready = 1'b0;
    mem_read_data  = 16'hDEAD;
    flush          = 1'b0;
    check({tag, " fetched"},   32'(fetcher_state), 32'(FS_FETCHED));
    check({tag, " instr"},     32'(instruction), 32'(data));
    check({tag, " no hit"},    32'(cache_hit), 32'd0);
    check({tag, " valid low"}, 32'(mem_read_valid), 32'd0);
  endtask

  task automatic decode_to_idle(input string tag);
    core_state = CS_DECODE;
    tick();
    check({tag, " back idle"}, 32'(fetcher_state), 32'(FS_IDLE));
    core_state = CS_IDLE;
  endtask

  initial begin
    reset          = 1'b0;
    core_state     = CS_IDLE;
    current_pc     = 8'h00;
    flush          = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    tick();
    tick();
    check("rst state", 32'(fetcher_state), 32'(FS_IDLE));
    check("rst valid", 32'(mem_read_valid), 32'd0);
    check("rst addr",  32'(mem_read_address), 32'd0);
    check("rst instr", 32'(instruction), 32'd0);
    check("rst hit",   32'(cache_hit), 32'd0);
    reset = 1'b1;
    tick();
    check("idle holds", 32'(fetcher_state), 32'(FS_IDLE));

    // Cold miss, 3-cycle memory latency.
    fetch_miss("cold", 8'h05, 16'h3123, 3, 1'b0);
    decode_to_idle("cold");

    // Hit with 1-cycle latency, then hold in FETCH for 10 cycles.
    core_state = CS_FETCH;
    current_pc = 8'h05;
    tick();
    check("hit state", 32'(fetcher_state), 32'(FS_FETCHED));
    check("hit instr", 32'(instruction), 32'h3123);
    check("hit pulse", 32'(cache_hit), 32'd1);
    check("hit valid", 32'(mem_read_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold state", 32'(fetcher_state), 32'(FS_FETCHED));
      check("hold instr", 32'(instruction), 32'h3123);
      check("hold valid", 32'(mem_read_valid), 32'd0);
      check("hold hit",   32'(cache_hit), 32'd0);
    end
    decode_to_idle("hold");

    // Conflict: 0x09 evicts 0x05 (both index 1); ready in first FETCHING cycle.
    fetch_miss("conf09", 8'h09, 16'h9A07, 2, 1'b0);
    decode_to_idle("conf09");
    fetch_miss("conf05", 8'h05, 16'h3123, 1, 1'b0);
    decode_to_idle("conf05");

    // Flush coinciding with a fill: data delivered, line left invalid.
    fetch_miss("flfill", 8'h22, 16'hF000, 2, 1'b1);
    decode_to_idle("flfill");
    fetch_miss("flrefetch", 8'h22, 16'hF000, 1, 1'b0);
    decode_to_idle("flrefetch");

    // Flush coinciding with a hit lookup: hit still served, then line is gone.
    core_state = CS_FETCH;
    current_pc = 8'h22;
    flush      = 1'b1;
    tick();
    flush = 1'b0;
    check("flhit state", 32'(fetcher_state), 32'(FS_FETCHED));
    check("flhit pulse", 32'(cache_hit), 32'd1);
    check("flhit instr", 32'(instruction), 32'hF000);
    decode_to_idle("flhit");
    fetch_miss("flafter", 8'h22, 16'hF000, 1, 1'b0);
    decode_to_idle("flafter");

    // Reset mid-fetch: immediate effect, later ready ignored, cache cleared.
    core_state = CS_FETCH;
    current_pc = 8'h13;
    tick();
    check("mid fetching", 32'(fetcher_state), 32'(FS_FETCHING));
    #2;
    reset = 1'b0;
    #1;
    check("async valid", 32'(mem_read_valid), 32'd0);
    check("async state", 32'(fetcher_state), 32'(FS_IDLE));
    check("async instr", 32'(instruction), 32'd0);
    tick();
    reset          = 1'b1;
    core_state     = CS_IDLE;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hBEEF;
    tick();
    mem_read_ready = 1'b0;
    check("stray state", 32'(fetcher_state), 32'(FS_IDLE));
    check("stray instr", 32'(instruction), 32'd0);
    check("stray valid", 32'(mem_read_valid), 32'd0);
    fetch_miss("postrst", 8'h05, 16'h3123, 2, 1'b0);
    decode_to_idle("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
